// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_arb_pkg
// Description : Shared definitions for the load-enable register arbiter.
//               - state_t       : controller state encoding (IDLE/LOAD/HOLD)
//               - DEFAULT_WIDTH : width of the shared load-enable register
//               - rr_wrap()     : modular index helper for round-robin search
// Revision    : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

  // Width of the external load-enable register this arbiter feeds.
  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  // (base + off) mod n; used to walk the requester ring starting after base.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage : reg_arb_pkg
`default_nettype wire

// File: rtl/reg_load_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches the request vector
//               starting at index (ptr+1) mod N and wrapping, returning the
//               first asserted requester.
// Ports       :
//   req    [N-1:0]  in  : request vector
//   ptr    [IW-1:0] in  : index of the previous winner
//   grant  [N-1:0]  out : one-hot winner (all zero when no request)
//   idx    [IW-1:0] out : winner index (zero when no request)
//   any             out : at least one request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Offsets 1..N visit every requester exactly once, the previous winner last,
  // so it only wins again when nobody else is asking.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IW'(rr_wrap(int'(ptr), off, N));
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_load_arbiter
// Description : Round-robin controller sharing one external load-enable
//               register among N_REQ requesters. A winner's data is captured,
//               presented on load/Data for exactly one cycle, then further
//               writes are held off for HOLD_CYCLES cycles so the display
//               downstream of the register sees every value.
// Ports       :
//   clk                        in  : clock, all logic on posedge
//   rst                        in  : synchronous active-high reset
//   req      [N_REQ-1:0]       in  : level requests, held until granted
//   req_data [N_REQ*WIDTH-1:0] in  : requester i data at [i*WIDTH +: WIDTH]
//   gnt      [N_REQ-1:0]       out : one-hot pulse, requester loaded this cycle
//   load                       out : register load enable
//   Data     [WIDTH-1:0]       out : register data (holds last captured value)
//   busy                       out : high in LOAD and HOLD
//   last_src [clog2(N_REQ)-1:0] out: index of most recent winner
// Revision    : 1.0 - initial release
// ============================================================================
module reg_load_arbiter
  import reg_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     load,
  output logic [WIDTH-1:0]         Data,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] last_src
);

  localparam int IW = $clog2(N_REQ);
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
  localparam logic [IW-1:0] PTR_RESET = IW'(N_REQ - 1);

  // Registered state
  state_t           state;
  logic [IW-1:0]    ptr;
  logic [HW-1:0]    hold_cnt;

  // Next-state values
  state_t           state_nxt;
  logic [IW-1:0]    ptr_nxt;
  logic [IW-1:0]    last_src_nxt;
  logic [HW-1:0]    hold_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic             load_nxt;
  logic             busy_nxt;

  // Picker results
  logic [N_REQ-1:0] win_onehot;
  logic [IW-1:0]    win_idx;
  logic             win_any;

  logic [WIDTH-1:0] data_arr [N_REQ];

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end
  endgenerate

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Outputs are computed for the state being entered and registered, so
  // load/gnt/busy line up with the state and nothing combinational reaches
  // from req to an output.
  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    last_src_nxt = last_src;
    hold_nxt     = hold_cnt;
    data_nxt     = Data;
    gnt_nxt      = '0;
    load_nxt     = 1'b0;
    busy_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (win_any) begin
          // Winner is committed here; later changes to its req are ignored.
          data_nxt     = data_arr[win_idx];
          last_src_nxt = win_idx;
          ptr_nxt      = win_idx;
          gnt_nxt      = win_onehot;
          load_nxt     = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = LOAD;
        end
      end

      LOAD: begin
        if (HOLD_CYCLES == 0) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt  = HOLD_INIT;
          busy_nxt  = 1'b1;
          state_nxt = HOLD;
        end
      end

      HOLD: begin
        // hold_cnt counts HOLD_CYCLES-1 down to 0, one HOLD cycle per value.
        if (hold_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - HW'(1);
          busy_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= PTR_RESET;
      last_src <= '0;
      hold_cnt <= '0;
      Data     <= '0;
      gnt      <= '0;
      load     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      last_src <= last_src_nxt;
      hold_cnt <= hold_nxt;
      Data     <= data_nxt;
      gnt      <= gnt_nxt;
      load     <= load_nxt;
      busy     <= busy_nxt;
    end
  end

endmodule : reg_load_arbiter
`default_nettype wire

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Round-robin controller that shares one 5-bit load-enable register (`clk`, `load`, `Data`, `Q`) among several requesters. It arbitrates requests, captures the winner's data, and drives the register's `load`/`Data` pins for exactly one cycle. It then holds off further writes for a programmable hold window so downstream logic (LED/7-seg display) sees each value.

## Interface
- `N_REQ`, 4: number of requesters (2–8).
- `WIDTH`, 5: data width; matches the shared register.
- `HOLD_CYCLES`, 4: idle cycles enforced after each load (0 allowed).
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N_REQ: level request per requester; held high until granted.
- `req_data` in N_REQ*WIDTH: requester i's data in bits [i*WIDTH +: WIDTH].
- `gnt` out N_REQ: one-hot, one-cycle pulse marking the requester whose data is loaded this cycle.
- `load` out 1: drives the register's `load` input.
- `Data` out WIDTH: drives the register's `Data` input.
- `busy` out 1: high in LOAD and HOLD states.
- `last_src` out clog2(N_REQ): index of the most recent winner.

## Operation
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If `req` is nonzero, pick the winner by round-robin. Search starts at index (`ptr`+1) mod N_REQ and wraps.
  - Capture the winner's `req_data` into `Data`, record the winner in `last_src`, set `ptr` to the winner, and go to LOAD.
  - If `req` is zero, stay in IDLE.
- LOAD:
  - `load`=1 and `gnt[last_src]`=1 for this cycle only.
  - If HOLD_CYCLES=0, go to IDLE; otherwise load `hold_cnt` with HOLD_CYCLES-1 and go to HOLD.
- HOLD:
  - `load`=0 and `gnt`=0.
  - Decrement `hold_cnt`; leave for IDLE when it is 0 (HOLD lasts exactly HOLD_CYCLES cycles).
- `req` is ignored outside IDLE; pending requests wait.
- A winner is committed once captured. If its `req` drops during LOAD, the load still occurs and `gnt` still pulses.
- `Data` keeps its last captured value outside LOAD. It changes only on a capture edge.
- `hold_cnt` width is clog2(HOLD_CYCLES+1), minimum 1.
- All outputs are registered. No combinational path runs from `req` to any output.

## Timing
- Reset values: state=IDLE, `load`=0, `gnt`=0, `Data`=0, `busy`=0, `last_src`=0.
- Reset sets `ptr`=N_REQ-1, so requester 0 wins first.
- Reset mid-LOAD or mid-HOLD aborts immediately: `load` is 0 in the cycle after the reset edge.
- Latency:
  - `req` high at edge k (in IDLE) gives `load`/`gnt` high during cycle k..k+1.
  - Register `Q` updates at edge k+1.
- Throughput: one load per 2+HOLD_CYCLES cycles under continuous requests.
- Fairness: with all requesters asserted, grants rotate 0,1,2,…,N_REQ-1,0,…
- A single requester asserting continuously is granted every window.
- Simultaneous events:
  - `rst` overrides everything.
  - A request arriving in the same cycle that HOLD exits is seen in IDLE on the next edge, never in HOLD.

## Structure
- Shared package `reg_arb_pkg`: state enum (IDLE/LOAD/HOLD) and default WIDTH=5.
- One sub-module, `rr_pick`:
  - Combinational.
  - Inputs: `req` and `ptr`.
  - Outputs: one-hot winner, winner index, and `any`.
  - Reusable by other shared-resource controllers.
- The top level instantiates `rr_pick`, the FSM, and the output registers. The register itself stays external.

## Test plan
- Reset check: assert `rst` 2 cycles, then release with `req`=0. All outputs stay 0 and state stays IDLE for 10 cycles.
- Single requester:
  - Stimulus: `req`=4'b0100 with data 5'd19 at edge k.
  - Response: `load`=1, `gnt`=4'b0100, `Data`=19 in cycle k+1; `busy` high 5 cycles; `last_src`=2.
- All requesters active:
  - Stimulus: `req`=4'b1111 with data 1,2,3,4.
  - Response: grants in order 0,1,2,3,0, loads spaced 6 cycles apart (HOLD_CYCLES=4), `Data` sequence 1,2,3,4,1.
- Request drop during LOAD:
  - Stimulus: requester 1 drops `req` in its LOAD cycle.
  - Response: `load`=1 and `gnt[1]`=1 still occur with the captured data; the next winner is requester 2 if it is pending.
- Reset in HOLD:
  - Stimulus: `rst` pulse 2 cycles into HOLD.
  - Response: next cycle shows state IDLE, outputs at reset values, `ptr` reset so requester 0 wins next.
- HOLD_CYCLES=0 build:
  - Stimulus: `req`=4'b0011 continuously.
  - Response: `load` high every other cycle, `gnt` alternating 0001/0010.
